// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester, command and response signals between the two ports, arbiter and SDRAM controller
interface sdram_port_arbiter_if #(
    parameter int AW = 23
);
    logic          p0_req;
    logic          p1_req;
    logic          p0_we;
    logic          p1_we;
    logic [AW-1:0] p0_addr;
    logic [AW-1:0] p1_addr;
    logic [7:0]    p0_din;
    logic [7:0]    p1_din;
    logic          p0_ack;
    logic          p1_ack;
    logic [7:0]    rd_data;
    logic          mem_we;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_done;
    logic          timeout_err;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_din, p1_din,
        input  mem_dout, mem_done,
        output p0_ack, p1_ack, rd_data, mem_we, mem_rd, mem_addr, mem_din, timeout_err
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_din, p1_din,
        output mem_dout, mem_done,
        input  p0_ack, p1_ack, rd_data, mem_we, mem_rd, mem_addr, mem_din, timeout_err
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port byte arbiter in front of an SDRAM controller; SDRAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module sdram_port_arbiter #(
    parameter int AW      = 23,
    parameter int TIMEOUT = 255
) (
    input logic                 clk_sys,
    input logic                 reset_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic          r_id;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_din;
    logic          r_mem_we;
    logic          r_mem_rd;
    logic [7:0]    r_rd_data;
    logic          r_timeout_err;
    logic [CW-1:0] r_cnt;
    logic          r_p0_ack;
    logic          r_p1_ack;
    logic          w_grant;
    logic          w_grant_id;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [7:0]    w_sel_din;
    logic          w_last_cycle;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic          r_last;
`endif

    // Reset asserts at once and releases two clk_sys edges after reset_n rises
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Arbitration, operand select and next-state decode
    always_comb begin
        w_grant      = 1'b0;
        w_grant_id   = 1'b0;
        w_sel_we     = 1'b0;
        w_sel_addr   = '0;
        w_sel_din    = 8'h00;
        w_last_cycle = (r_cnt == C_LAST);
        w_next       = r_state;

        // No grant while an ack is out: the acked requester still holds req in that cycle
        w_grant = (bus.p0_req | bus.p1_req) & ~(r_p0_ack | r_p1_ack);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        if (bus.p0_req && bus.p1_req) begin
            w_grant_id = ~r_last;
        end else begin
            w_grant_id = ~bus.p0_req;
        end
`else
        w_grant_id = ~bus.p0_req;
`endif
        w_sel_we   = w_grant_id ? bus.p1_we   : bus.p0_we;
        w_sel_addr = w_grant_id ? bus.p1_addr : bus.p0_addr;
        w_sel_din  = w_grant_id ? bus.p1_din  : bus.p0_din;

        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.mem_done || w_last_cycle) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched command, strobes, wait counter, read data and acks
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_id          <= 1'b0;
            r_addr        <= '0;
            r_din         <= 8'h00;
            r_mem_we      <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_rd_data     <= 8'h00;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_p0_ack      <= 1'b0;
            r_p1_ack      <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_mem_rd <= 1'b0;
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Strobe is registered here so it is high for the single ISSUE cycle
                    if (w_grant) begin
                        r_id     <= w_grant_id;
                        r_addr   <= w_sel_addr;
                        r_din    <= w_sel_din;
                        r_mem_we <= w_sel_we;
                        r_mem_rd <= ~w_sel_we;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // mem_done beats a timeout landing in the same cycle
                    if (bus.mem_done) begin
                        r_rd_data <= bus.mem_dout;
                    end else if (w_last_cycle) begin
                        r_rd_data     <= 8'hFF;
                        r_timeout_err <= 1'b1;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_p0_ack <= ~r_id;
                    r_p1_ack <= r_id;
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Last-grant memory; reset value 1 hands the first contested grant to p0
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_grant) begin
            r_last <= w_grant_id;
        end
    end
`endif

    assign bus.p0_ack      = r_p0_ack;
    assign bus.p1_ack      = r_p1_ack;
    assign bus.rd_data     = r_rd_data;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_din     = r_din;
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    int          t_ack_cyc;
    int          t_n_rd;
    int          t_n_we;
    int          t_bad_ack;
    logic [22:0] t_addr;
    logic [7:0]  t_din;
    logic [7:0]  t_data;

    sdram_port_arbiter_if #(.AW(23)) bus ();

    sdram_port_arbiter #(.AW(23), .TIMEOUT(8)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Cycle 0 raises req; mem_done goes high on WAIT cycle done_at (cycle done_at+1), 0 = never
    task automatic txn(input bit port, input bit we, input logic [22:0] addr, input logic [7:0] din,
                       input int done_at, input logic [7:0] dout);
        int c;
        bit acked;
        t_ack_cyc = -1;
        t_n_rd    = 0;
        t_n_we    = 0;
        t_bad_ack = 0;
        t_addr    = '0;
        t_din     = '0;
        t_data    = '0;
        if (port == 1'b0) begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_din = din;
        end else begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_din = din;
        end
        c     = 0;
        acked = 1'b0;
        while (!acked && c < 40) begin
            bus.mem_done = (done_at > 0) && (c == done_at + 1);
            bus.mem_dout = dout;
            if (bus.mem_rd) begin t_n_rd++; t_addr = bus.mem_addr; t_din = bus.mem_din; end
            if (bus.mem_we) begin t_n_we++; t_addr = bus.mem_addr; t_din = bus.mem_din; end
            if (port ? bus.p0_ack : bus.p1_ack) t_bad_ack++;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                acked     = 1'b1;
                t_ack_cyc = c;
                t_data    = bus.rd_data;
            end else begin
                tick();
                c++;
            end
        end
        tick();
        bus.mem_done = 1'b0;
        bus.p0_req   = 1'b0;
        bus.p1_req   = 1'b0;
        tick();
    endtask

    task automatic check_txn(input string tag, input int exp_lat, input bit we, input logic [22:0] addr,
                             input logic [7:0] din, input bit chk_data, input logic [7:0] exp_data,
                             input bit exp_err);
        chk({tag, "_latency"}, t_ack_cyc, exp_lat);
        chk({tag, "_rd_strobes"}, t_n_rd, we ? 0 : 1);
        chk({tag, "_we_strobes"}, t_n_we, we ? 1 : 0);
        chk({tag, "_mem_addr"}, 32'(t_addr), 32'(addr));
        if (we) chk({tag, "_mem_din"}, 32'(t_din), 32'(din));
        if (chk_data) chk({tag, "_rd_data"}, 32'(t_data), 32'(exp_data));
        chk({tag, "_other_ack"}, t_bad_ack, 0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(exp_err));
    endtask

    initial begin
        int order [5];
        int exp_order [5];
        int n, c, both, n_ack, n_strobe;
        bit pend;

        bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
        bus.p0_addr = '0; bus.p1_addr = '0; bus.p0_din = '0; bus.p1_din = '0;
        bus.mem_dout = '0; bus.mem_done = 0;

        repeat (3) tick();
        chk("rst_p0_ack", 32'(bus.p0_ack), 0);
        chk("rst_p1_ack", 32'(bus.p1_ack), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 0);
        reset_n = 1'b1;
        repeat (4) tick();

        txn(1'b1, 1'b0, 23'h000100, 8'h00, 1, 8'h5A);
        check_txn("p1_read", 4, 1'b0, 23'h000100, 8'h00, 1'b1, 8'h5A, 1'b0);

        txn(1'b0, 1'b1, 23'h7FFFFF, 8'hC3, 1, 8'h00);
        check_txn("p0_write", 4, 1'b1, 23'h7FFFFF, 8'hC3, 1'b0, 8'h00, 1'b0);

        txn(1'b1, 1'b0, 23'h0002A5, 8'h00, 8, 8'h3C);
        check_txn("done_at_timeout", 11, 1'b0, 23'h0002A5, 8'h00, 1'b1, 8'h3C, 1'b0);

        txn(1'b1, 1'b1, 23'h000ABC, 8'h55, 3, 8'h00);
        check_txn("p1_write_w3", 6, 1'b1, 23'h000ABC, 8'h55, 1'b0, 8'h00, 1'b0);

        // Both ports hold req; p0 drops the cycle after the fourth ack
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 1};
`else
        exp_order = '{0, 0, 0, 0, 1};
`endif
        order = '{9, 9, 9, 9, 9};
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 23'h000001;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 23'h000002;
        n = 0; c = 0; both = 0; pend = 0;
        while (n < 5 && c < 200) begin
            if (n >= 4) bus.p0_req = 0;
            bus.mem_done = pend;
            bus.mem_dout = 8'h11;
            pend = bus.mem_rd | bus.mem_we;
            if (bus.p0_ack && bus.p1_ack) both++;
            if (bus.p0_ack) begin order[n] = 0; n++; end
            else if (bus.p1_ack) begin order[n] = 1; n++; end
            tick();
            c++;
        end
        bus.p1_req = 0;
        bus.mem_done = 0;
        tick();
        for (int i = 0; i < 5; i++) chk($sformatf("arb_order_%0d", i), order[i], exp_order[i]);
        chk("arb_both_acks", both, 0);

        txn(1'b1, 1'b0, 23'h000777, 8'h00, 0, 8'h22);
        check_txn("timeout", 11, 1'b0, 23'h000777, 8'h00, 1'b1, 8'hFF, 1'b1);

        txn(1'b0, 1'b0, 23'h000042, 8'h00, 2, 8'h81);
        check_txn("after_timeout", 5, 1'b0, 23'h000042, 8'h00, 1'b1, 8'h81, 1'b1);

        // Reset pulsed in the second WAIT cycle
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 23'h123456;
        repeat (3) tick();
        chk("mid_rst_pre_addr", 32'(bus.mem_addr), 32'h123456);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        chk("mid_rst_timeout_err", 32'(bus.timeout_err), 0);
        chk("mid_rst_acks", 32'({bus.p0_ack, bus.p1_ack}), 0);
        bus.p0_req = 0;
        repeat (3) tick();
        #3;
        reset_n = 1'b1;
        tick();
        n_ack = 0; n_strobe = 0;
        for (int i = 0; i < 15; i++) begin
            bus.mem_done = (i == 5);
            bus.mem_dout = 8'h99;
            if (bus.p0_ack || bus.p1_ack) n_ack++;
            if (bus.mem_rd || bus.mem_we) n_strobe++;
            tick();
        end
        bus.mem_done = 0;
        chk("post_rst_acks", n_ack, 0);
        chk("post_rst_strobes", n_strobe, 0);
        chk("post_rst_stray_done", 32'(bus.rd_data), 0);

        txn(1'b0, 1'b0, 23'h000010, 8'h00, 1, 8'hE7);
        check_txn("post_rst_read", 4, 1'b0, 23'h000010, 8'h00, 1'b1, 8'hE7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
